onehot_encoder_pipe: RTL

Streaming one-hot to binary encoder. It is the inverse of the team's binary-to-one-hot decoder.
- Accepts a 2**CODE_WIDTH-bit one-hot word over a valid/ready handshake.
- Returns the binary index one cycle later, with an error flag for malformed (zero or multi-hot) words.
- Keeps a saturating error counter and a sticky error flag for status readback.
- Sits between one-hot request sources and binary-indexed consumers (mux selects, register-file addresses).

---
 rtl/onehot_encoder_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/onehot_encoder_pipe.sv
// Streaming one-hot to binary encoder with one output register stage and error status.
// Define ONEHOT_ENC_PRIORITY_EN to encode multi-hot words to their lowest set bit instead of flagging them.
module onehot_encoder_pipe #(
  parameter int unsigned CODE_WIDTH   = 3,
  parameter int unsigned ONEHOT_WIDTH = 2**CODE_WIDTH,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ONEHOT_WIDTH-1:0] in_onehot,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [CODE_WIDTH-1:0]   out_code,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic                    err_sticky
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                  out_valid_q, out_valid_d;
  logic [CODE_WIDTH-1:0] out_code_q, out_code_d;
  logic                  out_err_q, out_err_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic                  err_sticky_q, err_sticky_d;

  logic                  accept;
  logic                  found;
  logic                  multi;
  logic [CODE_WIDTH-1:0] low_idx;
  logic [CODE_WIDTH-1:0] enc_code;
  logic                  enc_err;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Scan from bit 0 so the first hit is the lowest set bit; any later hit marks multi-hot.
  always_comb begin
    found   = 1'b0;
    multi   = 1'b0;
    low_idx = '0;
    for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
      if (in_onehot[i]) begin
        if (!found) begin
          low_idx = CODE_WIDTH'(i);
          found   = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
    end
  end

`ifdef ONEHOT_ENC_PRIORITY_EN
  assign enc_err  = ~found;
  assign enc_code = low_idx;
`else
  assign enc_err  = ~found | multi;
  assign enc_code = enc_err ? '0 : low_idx;
`endif

  always_comb begin
    out_valid_d  = out_valid_q;
    out_code_d   = out_code_q;
    out_err_d    = out_err_q;
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_code_d  = enc_code;
      out_err_d   = enc_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A new error event takes precedence over a coincident clear.
    if (accept && enc_err) begin
      err_sticky_d = 1'b1;
      if (err_clr) begin
        err_count_d = CNT_ONE;
      end else if (err_count_q != '1) begin
        err_count_d = err_count_q + CNT_ONE;
      end
    end else if (err_clr) begin
      err_count_d  = '0;
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_code_q   <= '0;
      out_err_q    <= 1'b0;
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_code_q   <= out_code_d;
      out_err_q    <= out_err_d;
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_code   = out_code_q;
  assign out_err    = out_err_q;
  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;

endmodule
